// File: rtl/psone_pkg.sv
// psone_pkg -- shared constants and types for the PlayStation pad receiver.
//   PSONE_ID_DIGITAL / PSONE_ID_READY : expected ID bytes at packet offsets 1 and 2
//   psone_err_e                       : packet verdict codes reported on oERR_CODE
//   psone_tx_state_e                  : UART frame sequencer states
//   psone_classify()                  : folds the three packet checks into one code
package psone_pkg;

    localparam logic [7:0] PSONE_ID_DIGITAL = 8'h41;
    localparam logic [7:0] PSONE_ID_READY   = 8'h5A;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_LEN  = 2'd1,
        ERR_ID   = 2'd2,
        ERR_ACK  = 2'd3
    } psone_err_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } psone_tx_state_e;

    // Length problems mask ID problems, which mask ACK problems.
    function automatic psone_err_e psone_classify(input logic len_bad,
                                                  input logic id_bad,
                                                  input logic ack_bad);
        psone_err_e code;
        if (len_bad)      code = ERR_LEN;
        else if (id_bad)  code = ERR_ID;
        else if (ack_bad) code = ERR_ACK;
        else              code = ERR_NONE;
        return code;
    endfunction

endpackage

// File: rtl/psone_sync2.sv
// psone_sync2 -- two-flop synchroniser for asynchronous pad lines.
//   iCLK   : destination clock
//   iRESET : asynchronous active-high reset, output resets to 1 (idle pad level)
//   iD     : asynchronous input
//   oQ     : synchronised output, two iCLK cycles of latency
module psone_sync2 (
    input  logic iCLK,
    input  logic iRESET,
    input  logic iD,
    output logic oQ
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= iD;
            r_sync <= r_meta;
        end
    end

    assign oQ = r_sync;

endmodule

// File: rtl/psone_pad_rx.sv
// psone_pad_rx -- snoops a PlayStation pad SPI exchange, validates each packet and
// forwards accepted packets as a SYNC_BYTE-prefixed frame to a byte-wide UART.
//   iCLK, iRESET          : system clock, asynchronous active-high reset
//   iCS, iSCK             : SPI select (active low) and clock (idle high), iCLK-domain
//   iMISO, iACK           : pad data and acknowledge (active low), asynchronous
//   iTX_BUSY              : UART transmitter busy
//   oTX_ST, oTX_BYTE      : one-cycle UART start and the byte, held until busy falls
//   oBUTTONS              : {byte4, byte3} of the last accepted packet, active low
//   oPKT_VALID, oPKT_ERR  : one-cycle packet verdict pulses
//   oERR_CODE             : verdict code of the last packet, held until the next one
module psone_pad_rx
    import psone_pkg::*;
#(
    parameter int         PKT_BYTES = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iCS,
    input  logic        iSCK,
    input  logic        iMISO,
    input  logic        iACK,
    input  logic        iTX_BUSY,
    output logic        oTX_ST,
    output logic [7:0]  oTX_BYTE,
    output logic [15:0] oBUTTONS,
    output logic        oPKT_VALID,
    output logic        oPKT_ERR,
    output logic [1:0]  oERR_CODE
);

    localparam logic [3:0] LP_LEN     = 4'(PKT_BYTES);
    localparam logic [3:0] LP_ACK_MIN = 4'(PKT_BYTES - 1);
    localparam logic [4:0] LP_FRAME   = 5'(PKT_BYTES + 1);

    // Input conditioning
    logic w_miso_s;
    logic w_ack_s;
    logic r_cs_d;
    logic r_sck_d;
    logic r_ack_d;

    psone_sync2 u_sync_miso (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iD     (iMISO),
        .oQ     (w_miso_s)
    );

    psone_sync2 u_sync_ack (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iD     (iACK),
        .oQ     (w_ack_s)
    );

    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sck_rise;
    logic w_ack_fall;

    assign w_cs_fall  =  r_cs_d & ~iCS;
    assign w_cs_rise  = ~r_cs_d &  iCS;
    assign w_sck_rise = ~r_sck_d & iSCK & ~iCS;
    assign w_ack_fall =  r_ack_d & ~w_ack_s & ~iCS;

    // Capture
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic [3:0] r_byte_idx;
    logic [3:0] r_ack_cnt;
    logic       r_ovf;
    logic [7:0] r_cap [16];

    logic       w_byte_done;
    logic       w_cap_full;
    logic [7:0] w_new_byte;

    assign w_byte_done = w_sck_rise & (r_bit_cnt == 3'd7);
    assign w_cap_full  = (r_byte_idx == LP_LEN);
    // Bits arrive LSB first; the 8th sample is the MSB.
    assign w_new_byte  = {w_miso_s, r_shift};

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_cs_d     <= 1'b1;
            r_sck_d    <= 1'b1;
            r_ack_d    <= 1'b1;
            r_bit_cnt  <= 3'd0;
            r_byte_idx <= 4'd0;
            r_ack_cnt  <= 4'd0;
            r_ovf      <= 1'b0;
        end else begin
            r_cs_d  <= iCS;
            r_sck_d <= iSCK;
            r_ack_d <= w_ack_s;
            if (w_cs_fall) begin
                r_bit_cnt  <= 3'd0;
                r_byte_idx <= 4'd0;
                r_ack_cnt  <= 4'd0;
                r_ovf      <= 1'b0;
            end else begin
                if (w_sck_rise) begin
                    // 3-bit count wraps to 0 on the 8th sample
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_byte_done) begin
                        if (w_cap_full) r_ovf      <= 1'b1;
                        else            r_byte_idx <= r_byte_idx + 4'd1;
                    end
                end
                if (w_ack_fall && (r_ack_cnt != 4'hF)) begin
                    r_ack_cnt <= r_ack_cnt + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (w_sck_rise) begin
            r_shift <= {w_miso_s, r_shift[6:1]};
        end
        if (w_byte_done && !w_cap_full) begin
            r_cap[r_byte_idx] <= w_new_byte;
        end
    end

    // Packet verdict
    logic       w_len_bad;
    logic       w_id_bad;
    logic       w_ack_bad;
    psone_err_e w_verdict;
    logic       w_accept;

    assign w_len_bad = (r_bit_cnt != 3'd0) | (r_byte_idx != LP_LEN) | r_ovf;
    assign w_id_bad  = (r_cap[1] != PSONE_ID_DIGITAL) | (r_cap[2] != PSONE_ID_READY);
    assign w_ack_bad = (r_ack_cnt < LP_ACK_MIN);
    assign w_verdict = psone_classify(w_len_bad, w_id_bad, w_ack_bad);
    assign w_accept  = w_cs_rise & (w_verdict == ERR_NONE);

    logic       r_pkt_valid;
    logic       r_pkt_err;
    psone_err_e r_err_code;
    logic [15:0] r_buttons;

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_pkt_valid <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_buttons   <= 16'hFFFF;
        end else begin
            r_pkt_valid <= 1'b0;
            r_pkt_err   <= 1'b0;
            if (w_cs_rise) begin
                r_err_code <= w_verdict;
                if (w_verdict == ERR_NONE) begin
                    r_pkt_valid <= 1'b1;
                    r_buttons   <= {r_cap[4], r_cap[3]};
                end else begin
                    r_pkt_err <= 1'b1;
                end
            end
        end
    end

    // UART frame sequencer
    psone_tx_state_e r_state;
    psone_tx_state_e w_state_nxt;
    logic            w_issue;
    logic            w_load;
    logic [4:0]      r_tx_idx;
    logic [3:0]      w_tx_ptr;
    logic [7:0]      w_tx_sel;
    logic [7:0]      r_txbuf [16];
    logic            r_tx_st;
    logic [7:0]      r_tx_byte;

    // r_tx_idx counts bytes already issued; index 0 is the sync header.
    assign w_tx_ptr = 4'(r_tx_idx - 5'd1);
    assign w_tx_sel = (r_tx_idx == 5'd0) ? SYNC_BYTE : r_txbuf[w_tx_ptr];

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!iTX_BUSY) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (iTX_BUSY) w_state_nxt = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!iTX_BUSY) begin
                    w_state_nxt = (r_tx_idx < LP_FRAME) ? ST_SEND : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_tx_st   <= 1'b0;
            r_tx_byte <= 8'h00;
            r_tx_idx  <= 5'd0;
        end else begin
            r_tx_st <= w_issue;
            if (w_load) begin
                r_tx_idx <= 5'd0;
            end else if (w_issue) begin
                r_tx_idx  <= r_tx_idx + 5'd1;
                r_tx_byte <= w_tx_sel;
            end
        end
    end

    // The TX buffer is only reloaded from IDLE, so a packet accepted mid-frame
    // cannot disturb the bytes still being sent.
    always_ff @(posedge iCLK) begin
        if (w_load) begin
            for (int i = 0; i < 16; i++) begin
                r_txbuf[i] <= r_cap[i];
            end
        end
    end

    assign oTX_ST     = r_tx_st;
    assign oTX_BYTE   = r_tx_byte;
    assign oBUTTONS   = r_buttons;
    assign oPKT_VALID = r_pkt_valid;
    assign oPKT_ERR   = r_pkt_err;
    assign oERR_CODE  = r_err_code;

endmodule

// File: tb/tb_psone_pad_rx.sv
module tb_psone_pad_rx;

    localparam int         PKT_BYTES = 8;
    localparam logic [7:0] SYNC      = 8'hA5;

    logic        iCLK = 1'b0;
    logic        iRESET;
    logic        iCS;
    logic        iSCK;
    logic        iMISO;
    logic        iACK;
    logic        iTX_BUSY;
    logic        oTX_ST;
    logic [7:0]  oTX_BYTE;
    logic [15:0] oBUTTONS;
    logic        oPKT_VALID;
    logic        oPKT_ERR;
    logic [1:0]  oERR_CODE;

    psone_pad_rx #(.PKT_BYTES(PKT_BYTES), .SYNC_BYTE(SYNC)) dut (
        .iCLK       (iCLK),
        .iRESET     (iRESET),
        .iCS        (iCS),
        .iSCK       (iSCK),
        .iMISO      (iMISO),
        .iACK       (iACK),
        .iTX_BUSY   (iTX_BUSY),
        .oTX_ST     (oTX_ST),
        .oTX_BYTE   (oTX_BYTE),
        .oBUTTONS   (oBUTTONS),
        .oPKT_VALID (oPKT_VALID),
        .oPKT_ERR   (oPKT_ERR),
        .oERR_CODE  (oERR_CODE)
    );

    always #5 iCLK = ~iCLK;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state: verdict of the packet just ended, due on cycle pend_cyc
    int          pend_cyc = -1;
    logic [1:0]  pend_code = 2'd0;
    logic [7:0]  pend_bytes [16];
    logic [7:0]  pkt [16];
    logic [15:0] exp_buttons = 16'hFFFF;
    logic [1:0]  exp_code = 2'd0;
    logic [7:0]  exp_q [$];
    logic [7:0]  rx_log [$];
    int          busy_len = 6;
    int          busy_cnt = 0;
    logic [7:0]  cur_byte = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge iCLK);
        cyc++;
    end

    // Compare process, also acting as the UART: every negedge
    initial begin
        iTX_BUSY = 1'b0;
        forever begin
            @(negedge iCLK);
            if (iRESET) begin
                exp_q.delete();
                pend_cyc    = -1;
                exp_buttons = 16'hFFFF;
                exp_code    = 2'd0;
                busy_cnt    = 0;
                iTX_BUSY    = 1'b0;
                chk("rst_tx_st", oTX_ST, 0);
                chk("rst_tx_byte", oTX_BYTE, 0);
            end else if (cyc == pend_cyc) begin
                exp_code = pend_code;
                if (pend_code == 2'd0) begin
                    exp_buttons = {pend_bytes[4], pend_bytes[3]};
                    if (exp_q.size() == 0 && iTX_BUSY == 1'b0) begin
                        exp_q.push_back(SYNC);
                        for (int k = 0; k < PKT_BYTES; k++) exp_q.push_back(pend_bytes[k]);
                    end
                end
            end
            chk("pkt_valid", oPKT_VALID, (!iRESET && cyc == pend_cyc && pend_code == 2'd0));
            chk("pkt_err", oPKT_ERR, (!iRESET && cyc == pend_cyc && pend_code != 2'd0));
            chk("err_code", oERR_CODE, exp_code);
            chk("buttons", oBUTTONS, exp_buttons);
            if (oTX_ST) begin
                chk("tx_while_busy", iTX_BUSY, 0);
                chk("tx_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("tx_byte", oTX_BYTE, exp_q.pop_front());
                rx_log.push_back(oTX_BYTE);
                cur_byte = oTX_BYTE;
                busy_cnt = busy_len;
                iTX_BUSY = 1'b1;
            end else if (busy_cnt > 0) begin
                chk("tx_hold", oTX_BYTE, cur_byte);
                busy_cnt--;
                if (busy_cnt == 0) iTX_BUSY = 1'b0;
            end
        end
    end

    task automatic set_pkt(input logic [63:0] v);
        for (int k = 0; k < 8; k++) pkt[k] = v[63-8*k -: 8];
    endtask

    task automatic spi_byte(input logic [7:0] b, input int nbits, input bit ack);
        for (int i = 0; i < nbits; i++) begin
            @(posedge iCLK); #1;
            iSCK  = 1'b0;
            iMISO = b[i];
            repeat (3) @(posedge iCLK);
            #1 iSCK = 1'b1;
            repeat (2) @(posedge iCLK);
        end
        if (ack) begin
            #1 iACK = 1'b0;
            repeat (3) @(posedge iCLK);
            #1 iACK = 1'b1;
            repeat (2) @(posedge iCLK);
        end
    endtask

    task automatic send_pkt(input int nfull, input int xbits, input int nacks);
        logic [1:0] code;
        @(posedge iCLK); #1;
        iCS = 1'b0;
        repeat (3) @(posedge iCLK);
        for (int k = 0; k < nfull; k++) spi_byte(pkt[k], 8, (k < nacks));
        if (xbits > 0) spi_byte(pkt[nfull], xbits, 1'b0);
        repeat (6) @(posedge iCLK);
        #1 iCS = 1'b1;
        if (xbits != 0 || nfull != PKT_BYTES)              code = 2'd1;
        else if (pkt[1] != 8'h41 || pkt[2] != 8'h5A)       code = 2'd2;
        else if (nacks < PKT_BYTES - 1)                    code = 2'd3;
        else                                               code = 2'd0;
        for (int k = 0; k < 16; k++) pend_bytes[k] = pkt[k];
        pend_code = code;
        pend_cyc  = cyc + 1;
        repeat (4) @(posedge iCLK);
    endtask

    task automatic wait_frame();
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && iTX_BUSY == 1'b0) && t < 6000) begin
            @(posedge iCLK);
            t++;
        end
        chk("frame_done", (t < 6000), 1);
        repeat (4) @(posedge iCLK);
    endtask

    task automatic chk_log(input logic [71:0] v, input int start);
        chk("frame_len", rx_log.size(), start + 9);
        for (int k = 0; k < 9; k++) begin
            if (start + k < rx_log.size()) chk("frame_byte", rx_log[start+k], v[71-8*k -: 8]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout wanted completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        iRESET = 1'b1;
        iCS    = 1'b1;
        iSCK   = 1'b1;
        iMISO  = 1'b1;
        iACK   = 1'b1;
        for (int k = 0; k < 16; k++) pkt[k] = 8'h00;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        chk("reset_buttons", oBUTTONS, 16'hFFFF);
        chk("reset_code", oERR_CODE, 0);
        chk("reset_valid", oPKT_VALID, 0);
        chk("reset_tx_byte", oTX_BYTE, 8'h00);
        @(posedge iCLK); #1 iRESET = 1'b0;
        repeat (5) @(posedge iCLK);

        // Good packet
        n = rx_log.size();
        set_pkt(64'hFF415A7FFE000000);
        send_pkt(8, 0, 7);
        wait_frame();
        chk("good_buttons", oBUTTONS, 16'hFE7F);
        chk("good_code", oERR_CODE, 0);
        chk_log(72'hA5FF415A7FFE000000, n);

        // Bad ID byte
        n = rx_log.size();
        set_pkt(64'hFF735A7FFE000000);
        send_pkt(8, 0, 7);
        repeat (20) @(posedge iCLK);
        chk("id_code", oERR_CODE, 2);
        chk("id_no_tx", rx_log.size(), n);

        // Short packet: 6 bytes plus 5 bits
        set_pkt(64'hFF415A1122000000);
        send_pkt(6, 5, 6);
        repeat (20) @(posedge iCLK);
        chk("short_code", oERR_CODE, 1);
        chk("short_buttons", oBUTTONS, 16'hFE7F);

        // Too few ACKs
        set_pkt(64'hFF415A3CC3000000);
        send_pkt(8, 0, 5);
        repeat (20) @(posedge iCLK);
        chk("ack_code", oERR_CODE, 3);

        // Ninth byte attempted
        set_pkt(64'hFF415A3CC3000000);
        send_pkt(9, 0, 8);
        repeat (20) @(posedge iCLK);
        chk("long_code", oERR_CODE, 1);
        chk("long_buttons", oBUTTONS, 16'hFE7F);

        // Second packet accepted while a slow frame is in flight
        busy_len = 150;
        n = rx_log.size();
        set_pkt(64'hFF415A7FFE000000);
        send_pkt(8, 0, 7);
        set_pkt(64'hFF415A1234000000);
        send_pkt(8, 0, 7);
        chk("mid_valid_code", oERR_CODE, 0);
        chk("mid_buttons", oBUTTONS, 16'h3412);
        chk("mid_in_flight", (rx_log.size() < n + 9), 1);
        wait_frame();
        chk_log(72'hA5FF415A7FFE000000, n);

        // Reset in WAIT_LO
        busy_len = 20;
        n = rx_log.size();
        set_pkt(64'hFF415A5566000000);
        send_pkt(8, 0, 7);
        t = 0;
        while (rx_log.size() < n + 2 && t < 2000) begin
            @(posedge iCLK);
            t++;
        end
        chk("pre_reset_bytes", (t < 2000), 1);
        repeat (5) @(posedge iCLK);
        #1 iRESET = 1'b1;
        @(negedge iCLK);
        chk("midrst_buttons", oBUTTONS, 16'hFFFF);
        chk("midrst_tx_byte", oTX_BYTE, 8'h00);
        chk("midrst_tx_st", oTX_ST, 0);
        chk("midrst_code", oERR_CODE, 0);
        @(posedge iCLK); #1 iRESET = 1'b0;
        repeat (300) @(posedge iCLK);
        chk("no_tx_after_reset", rx_log.size(), n + 2);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
